// File: rtl/pipe_addsub_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_addsub_if
// Purpose  : Operand/result bundle for pipe_addsub. It carries the valid/ready
//            handshake on both sides, the operands, and the result flags.
// Modports : master - operand producer and result consumer (testbench or
//                     upstream/downstream logic)
//            slave  - the pipe_addsub datapath
// Signals  : in_valid/in_ready, op_sub, a, b, cin       (operand side)
//            out_valid/out_ready, sum, cout, ovf, zero  (result side)
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, op_sub, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, op_sub, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipe_addsub
// Purpose  : Pipelined WIDTH-bit adder/subtractor. The operation is split into
//            STAGES slices of SW = WIDTH/STAGES bits. Each stage adds one slice
//            and passes a registered carry to the next stage. The result
//            carries carry-out, signed overflow and zero flags. Both sides use
//            a valid/ready handshake, and backpressure stalls the whole pipe.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - pipe_addsub_if.slave (operands, handshakes, result flags)
// Params   : WIDTH  - operand/result width, must be a multiple of STAGES
//            STAGES - pipeline depth and slice count (1..WIDTH)
// Options  : PIPE_ADDSUB_SAT_EN - when defined, a signed overflow clamps sum
//            to the signed extreme. ovf and cout still report the raw result.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_addsub_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    // Signed extremes used when saturation is built in.
    localparam logic [WIDTH-1:0] c_smax = {WIDTH{1'b1}} >> 1;
    localparam logic [WIDTH-1:0] c_smin = ~c_smax;

    // Per-stage pipeline registers. Index k holds the state after stage k.
    // r_a/r_b carry the full operands so that later stages can read their
    // own slice. r_s holds the sum slices built so far. For the last stage,
    // r_s holds the final (possibly saturated) sum.
    logic             r_v [STAGES];
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_ovf;
    logic             r_zero;

    // Stage inputs: stage 0 reads the bus, and stage k reads stage k-1.
    logic [WIDTH-1:0] w_a_src [STAGES];
    logic [WIDTH-1:0] w_b_src [STAGES];
    logic [WIDTH-1:0] w_s_src [STAGES];
    logic             w_c_src [STAGES];
    logic [WIDTH-1:0] w_s_nxt [STAGES];
    logic             w_c_nxt [STAGES];
    logic [SW:0]      w_slice;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_fin;
    logic             w_a_msb;
    logic             w_ovf;
    logic             w_zero;
    logic             w_stall;

    // The whole pipe freezes only when a finished result is waiting. Bubbles
    // in the pipe therefore never block new operands.
    assign w_stall = r_v[STAGES-1] && !bus.out_ready;

    always_comb begin
        // Subtraction is a + ~b + !cin, so the carry-in becomes a borrow-in.
        w_a_src[0] = bus.a;
        w_b_src[0] = bus.op_sub ? ~bus.b : bus.b;
        w_c_src[0] = bus.op_sub ? ~bus.cin : bus.cin;
        w_s_src[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_a_src[k] = r_a[k-1];
            w_b_src[k] = r_b[k-1];
            w_s_src[k] = r_s[k-1];
            w_c_src[k] = r_c[k-1];
        end

        w_slice = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_slice = {1'b0, w_a_src[k][k*SW +: SW]}
                    + {1'b0, w_b_src[k][k*SW +: SW]}
                    + {{SW{1'b0}}, w_c_src[k]};
            w_s_nxt[k]             = w_s_src[k];
            w_s_nxt[k][k*SW +: SW] = w_slice[SW-1:0];
            w_c_nxt[k]             = w_slice[SW];
        end
    end

    // Result flags for the last stage. Overflow compares A against the
    // effective B, which is already inverted for subtraction.
    always_comb begin
        w_raw   = w_s_nxt[STAGES-1];
        w_a_msb = w_a_src[STAGES-1][WIDTH-1];
        w_ovf   = (w_a_msb == w_b_src[STAGES-1][WIDTH-1]) &&
                  (w_raw[WIDTH-1] != w_a_msb);
`ifdef PIPE_ADDSUB_SAT_EN
        // The operands share a sign on overflow, so A's sign selects the
        // extreme to clamp to.
        w_fin   = w_ovf ? (w_a_msb ? c_smin : c_smax) : w_raw;
`else
        w_fin   = w_raw;
`endif
        w_zero  = (w_fin == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (!w_stall) begin
            // in_ready equals !w_stall, so every in_valid seen here is accepted.
            r_v[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_v[k] <= r_v[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= w_a_src[k];
                r_b[k] <= w_b_src[k];
                r_s[k] <= w_s_nxt[k];
                r_c[k] <= w_c_nxt[k];
            end
            // The last stage stores the final sum instead of the raw slice sum.
            r_s[STAGES-1] <= w_fin;
            r_ovf         <= w_ovf;
            r_zero        <= w_zero;
        end
    end

    assign bus.in_ready  = !w_stall;
    assign bus.out_valid = r_v[STAGES-1];
    assign bus.sum       = r_s[STAGES-1];
    assign bus.cout      = r_c[STAGES-1];
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_addsub
// Purpose  : Self-checking bench for pipe_addsub (WIDTH=8, STAGES=2). It runs
//            directed cases for reset, latency, carries, borrows, overflow,
//            backpressure and mid-flight reset, then a randomised stream. Every
//            result is checked against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_addsub;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int SMAX   = (1 << (WIDTH - 1)) - 1;
    localparam int SMIN   = -(1 << (WIDTH - 1));

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

    pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int               n_vec = 0;
    int               n_err = 0;
    res_t             exp_q[$];
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_sum   = '0;
    logic             acc;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain unsigned and signed integer arithmetic.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        int   ua, ub, sa, sb, ures, sres;
        res_t r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            ures   = ua + ub + int'(cin);
            sres   = sa + sb + int'(cin);
            r.cout = (ures > (1 << WIDTH) - 1);
        end else begin
            ures   = ua - ub - int'(cin);
            sres   = sa - sb - int'(cin);
            r.cout = (ures >= 0);
        end
        r.ovf = (sres > SMAX) || (sres < SMIN);
        r.sum = ures[WIDTH-1:0];
`ifdef PIPE_ADDSUB_SAT_EN
        if (r.ovf) r.sum = (sres > SMAX) ? WIDTH'(SMAX) : WIDTH'(SMIN);
`endif
        r.zero = (r.sum == '0);
        return r;
    endfunction

    // One cycle. Drive the inputs after the falling edge, then sample a little
    // later. The handshakes seen here are the ones that complete at the next
    // rising edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ic, input logic isub, input logic ordy, output logic accepted);
        res_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.a         = ia;
        bus.b         = ib;
        bus.cin       = ic;
        bus.op_sub    = isub;
        bus.out_ready = ordy;
        #1;
        if (prev_stall) begin
            check_val("hold_valid", bus.out_valid, 1'b1);
            check_val("hold_sum", bus.sum, prev_sum);
        end
        check_val("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", bus.sum, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check_val("sum", bus.sum, e.sum);
                check_val("cout", bus.cout, e.cout);
                check_val("ovf", bus.ovf, e.ovf);
                check_val("zero", bus.zero, e.zero);
            end
        end
        accepted = bus.in_valid && bus.in_ready;
        if (accepted) exp_q.push_back(model(ia, ib, ic, isub));
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_sum   = bus.sum;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        check_val(tag, exp_q.size(), 0);
    endtask

    // Offer one beat and check the no-stall latency of exactly STAGES cycles.
    task automatic beat_latency(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                input logic ic, input logic isub, input string tag);
        step(1'b1, ia, ib, ic, isub, 1'b1, acc);
        check_val({tag, "_acc"}, acc, 1'b1);
        for (int i = 1; i < STAGES; i++) begin
            idle(1);
            check_val({tag, "_early"}, bus.out_valid, 1'b0);
        end
        idle(1);
        check_val({tag, "_lat"}, bus.out_valid, 1'b1);
        drain({tag, "_drain"});
    endtask

    initial begin
        int stall_left;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_out_valid", bus.out_valid, 1'b0);
        check_val("rst_sum", bus.sum, '0);
        check_val("rst_flags", {bus.cout, bus.ovf, bus.zero}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_in_ready", bus.in_ready, 1'b1);

        // Directed cases
        beat_latency(8'h3C, 8'h05, 1'b0, 1'b0, "t1_basic");
        beat_latency(8'hFF, 8'h01, 1'b0, 1'b0, "t2_carry");
        beat_latency(8'h10, 8'h20, 1'b1, 1'b1, "t3_borrow");
        beat_latency(8'h80, 8'h01, 1'b0, 1'b1, "t3_subovf");
        beat_latency(8'h7F, 8'h01, 1'b0, 1'b0, "t4_addovf");
        beat_latency(8'h00, 8'h00, 1'b1, 1'b1, "t4_negone");

        // Backpressure: six back-to-back beats, with a 3-cycle stall after beat 3
        stall_left = 0;
        for (int i = 1; i <= 6; i++) begin
            int tries;
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 20) begin
                step(1'b1, WIDTH'(i), WIDTH'(i), 1'b0, 1'b0, stall_left == 0, acc);
                if (stall_left > 0) stall_left--;
                tries++;
            end
            check_val("t5_accept", acc, 1'b1);
            if (i == 3) stall_left = 3;
        end
        drain("t5_drain");

        // Reset while beats are in flight
        step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b1, acc);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        check_val("t6_rst_valid", bus.out_valid, 1'b0);
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check_val("t6_quiet", bus.out_valid, 1'b0);
        end
        beat_latency(8'h01, 8'h01, 1'b0, 1'b0, "t6_after");

        // Randomised stream with random backpressure
        for (int i = 0; i < 400; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if ($urandom_range(0, 7) == 0) ra = WIDTH'(8'h7F + $urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rb = WIDTH'(8'hFF * $urandom_range(0, 1));
            step($urandom_range(0, 9) < 7, ra, rb, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, acc);
        end
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end
endmodule
`default_nettype wire

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined adder/subtractor; successor to the fixed 2-bit combinational adder.
- Splits a WIDTH-bit add/sub into STAGES carry-registered slices to close timing at large widths.
- Adds a per-operation add/sub select, carry-in, carry-out, signed overflow and zero flags.
- Uses valid/ready handshake on both sides with full-pipeline backpressure; sits between operand producers and ALU/result consumers.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 2, pipeline depth and slice count; slice width SW = WIDTH/STAGES; range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts beat this cycle.
- op_sub  input  1  0 = a+b+cin; 1 = a-b-cin (borrow-in).
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  add: carry out of MSB; sub: raw carry, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (async, rst_n=0): all stage valid bits, sum, cout, ovf, zero = 0; out_valid = 0; in_ready is 1 after reset deasserts.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stall = out_valid && !out_ready. in_ready = !stall. On stall, every stage register holds; no beat is lost or duplicated.
- When not stalled, all stages advance each cycle; bubbles (valid=0) propagate.
- Latency: exactly STAGES cycles from accepted beat to out_valid with no stall. Throughput: 1 beat/cycle.
- Sub is implemented as a + ~b + !cin, giving a - b - cin.
- Stage k (0-based) adds slice k (bits SW*k+SW-1 : SW*k) of A and effective B plus the registered carry from stage k-1; stage 0 uses the effective carry-in.
- Upper operand slices and already-computed lower sum slices are delayed in shift registers alongside.
- cout = carry out of the final slice.
- ovf = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]), with Beff = ~b for sub.
- zero is computed from the final sum, after any saturation.
- Outputs are registered and held stable while out_valid && !out_ready.
- STAGES=1: single registered add, latency 1.
- Wrap-around: without saturation, sum is modulo 2^WIDTH.
- Simultaneous out accept and in accept in one cycle: both occur; the pipeline advances.
- Reset asserted mid-operation: all in-flight beats are discarded immediately; there is no partial output.

Optional Feature:
- Macro PIPE_ADDSUB_SAT_EN.
- Defined: when ovf=1, sum clamps to the signed extreme: {0,1..1} if A[MSB]=0, else {1,0..0}. ovf and cout still report the raw condition.
- Not defined: sum wraps modulo 2^WIDTH; no saturation logic is built.

Test Plan:
- Test 1, reset and latency (WIDTH=8, STAGES=2):
  - Stimulus: release reset; send a=0x3C, b=0x05, cin=0, op_sub=0, out_ready=1.
  - Response: out_valid exactly 2 cycles later; sum=0x41, cout=0, ovf=0, zero=0.
- Test 2, carry across slices:
  - Stimulus: a=0xFF, b=0x01, cin=0, add.
  - Response: sum=0x00, cout=1, ovf=0, zero=1.
- Test 3, subtract with borrow:
  - Stimulus: a=0x10, b=0x20, cin=1, op_sub=1.
  - Response: sum=0xEF, cout=0, ovf=0. Second case: a=0x80, b=0x01, sub, cin=0 -> sum=0x7F, ovf=1.
- Test 4, signed overflow add:
  - Stimulus: a=0x7F, b=0x01, add.
  - Response: ovf=1. Without the macro, sum=0x80; with PIPE_ADDSUB_SAT_EN, sum=0x7F.
- Test 5, backpressure:
  - Stimulus: stream 6 back-to-back beats (a=i, b=i, i=1..6); hold out_ready=0 for 3 cycles mid-stream.
  - Response: in_ready=0 during the stall; outputs 2,4,6,8,10,12 in order with no loss or duplication; sum stable while stalled.
- Test 6, reset mid-flight:
  - Stimulus: accept 2 beats, then assert rst_n=0 for 1 cycle.
  - Response: out_valid=0 immediately and stays 0 until new beats arrive; the next beat (a=1, b=1) returns sum=2 after 2 cycles.
